fetch_pc_unit: RTL and testbench

- Instruction-fetch front end of the pipelined CPU: owns the program counter, selects the next PC (sequential, ID jump, EX branch redirect), drives the instruction-memory address, and registers the IF/ID pipeline latch.
- Sits directly upstream of the 2:1 PC-select and operand muxes in the decode stage; its IF/ID outputs feed decode unchanged.
- Handles stall, flush and post-reset boot bubble.

---
 rtl/fetch_pc_if.sv | 29 ++
 rtl/fetch_pc_unit.sv | 116 +++++++++++
 tb/tb_fetch_pc_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: control and target inputs, the imem port and the IF/ID latch outputs.
// The bench or upstream logic uses the master side; fetch_pc_unit uses the slave side.
interface fetch_pc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] ifid_pc;
  logic [WIDTH-1:0] ifid_pc4;
  logic [WIDTH-1:0] ifid_ins;
  logic             ifid_valid;
  logic             misalign;
  logic [WIDTH-1:0] fetch_count;

  modport master (
    output stall, redirect, redirect_target, jump, jump_target, imem_rdata,
    input  pc_out, ifid_pc, ifid_pc4, ifid_ins, ifid_valid, misalign, fetch_count
  );

  modport slave (
    input  stall, redirect, redirect_target, jump, jump_target, imem_rdata,
    output pc_out, ifid_pc, ifid_pc4, ifid_ins, ifid_valid, misalign, fetch_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, next-PC selection, and the IF/ID latch
// with stall, flush and post-reset boot bubble.
module fetch_pc_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0080
) (
  input logic        clk,
  input logic        reset,
  fetch_pc_if.slave  fif
);

  typedef enum logic [1:0] {StBoot, StRun, StBubble} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [WIDTH-1:0] ifid_ins_q, ifid_ins_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic             active;
  logic             take_redirect;
  logic             hold;
  logic             take_jump;
  logic             advance;
  logic [WIDTH-1:0] pc_plus4;

  // Priority: redirect > stall > jump > sequential; everything is ignored in boot.
  assign active        = (state_q != StBoot);
  assign take_redirect = active && fif.redirect;
  assign hold          = active && !fif.redirect && fif.stall;
  assign take_jump     = active && !fif.redirect && !fif.stall && fif.jump;
  assign advance       = active && !fif.redirect && !fif.stall && !fif.jump;
  assign pc_plus4      = pc_q + WIDTH'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRun;
    if (!active) begin
      state_d = StRun;
    end else if (take_redirect || take_jump) begin
      state_d = StBubble;
    end else if (hold) begin
      state_d = state_q;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_ins_d    = ifid_ins_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = 1'b0;
    if (!active || take_redirect || take_jump) begin
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_ins_d   = '0;
      ifid_valid_d = 1'b0;
    end
    if (take_redirect) begin
      pc_d       = {fif.redirect_target[WIDTH-1:2], 2'b00};
      misalign_d = |fif.redirect_target[1:0];
    end else if (take_jump) begin
      pc_d       = {fif.jump_target[WIDTH-1:2], 2'b00};
      misalign_d = |fif.jump_target[1:0];
    end else if (advance) begin
      pc_d          = pc_plus4;
      ifid_pc_d     = pc_q;
      ifid_pc4_d    = pc_plus4;
      ifid_ins_d    = fif.imem_rdata;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifid_pc_q     <= '0;
      ifid_pc4_q    <= '0;
      ifid_ins_q    <= '0;
      ifid_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_ins_q    <= ifid_ins_d;
      ifid_valid_q  <= ifid_valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fif.pc_out      = pc_q;
  assign fif.ifid_pc     = ifid_pc_q;
  assign fif.ifid_pc4    = ifid_pc4_q;
  assign fif.ifid_ins    = ifid_ins_q;
  assign fif.ifid_valid  = ifid_valid_q;
  assign fif.misalign    = misalign_q;
  assign fif.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random control traffic, checked every
// cycle against a behavioural fetch model.
module tb_fetch_pc_unit;

  localparam int unsigned WIDTH = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0080;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fetch_pc_if #(.WIDTH(WIDTH)) bus ();

  fetch_pc_unit #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (bus.slave)
  );

  // Combinational instruction memory: the word at address A is 0x1111_0000 + A.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1111_0000 + addr;
  endfunction

  assign bus.imem_rdata = mem_word(bus.pc_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_ifid_ins, m_count;
  logic        m_valid, m_mis, m_boot;

  task automatic model_reset();
    m_pc = RESET_PC;
    m_ifid_pc = '0; m_ifid_pc4 = '0; m_ifid_ins = '0; m_valid = 1'b0;
    m_mis = 1'b0; m_count = '0; m_boot = 1'b1;
  endtask

  task automatic model_flush(input logic [31:0] tgt);
    m_pc = tgt & 32'hFFFF_FFFC;
    m_mis = (tgt[1:0] != 2'b00);
    m_ifid_pc = '0; m_ifid_pc4 = '0; m_ifid_ins = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (m_boot) begin
      m_boot = 1'b0;
      m_mis = 1'b0;
      m_ifid_pc = '0; m_ifid_pc4 = '0; m_ifid_ins = '0; m_valid = 1'b0;
    end else if (bus.redirect) begin
      model_flush(bus.redirect_target);
    end else if (bus.stall) begin
      m_mis = 1'b0;
    end else if (bus.jump) begin
      model_flush(bus.jump_target);
    end else begin
      m_mis = 1'b0;
      m_ifid_pc = m_pc;
      m_ifid_pc4 = m_pc + 32'd4;
      m_ifid_ins = mem_word(m_pc);
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".pc_out"},      bus.pc_out,              m_pc);
    check({where, ".ifid_pc"},     bus.ifid_pc,             m_ifid_pc);
    check({where, ".ifid_pc4"},    bus.ifid_pc4,            m_ifid_pc4);
    check({where, ".ifid_ins"},    bus.ifid_ins,            m_ifid_ins);
    check({where, ".ifid_valid"},  {31'd0, bus.ifid_valid}, {31'd0, m_valid});
    check({where, ".misalign"},    {31'd0, bus.misalign},   {31'd0, m_mis});
    check({where, ".fetch_count"}, bus.fetch_count,         m_count);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rt,
                       input logic jp, input logic [31:0] jt);
    bus.stall = st; bus.redirect = rd; bus.redirect_target = rt;
    bus.jump = jp; bus.jump_target = jt;
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  // Asynchronous reset pulse placed between edges; values must change before any edge.
  task automatic async_reset(input string where);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(where);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Boot bubble, then sequential fetch from the entry point.
    for (int i = 0; i < 4; i++) step("seq");

    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step("stall");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("unstall");

    // Redirect must win over a concurrent stall and jump.
    drive(1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0400);
    step("redir");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("redir_after");

    drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0303);
    step("jump_mis");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("jump_after");
    step("jump_after2");

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    step("wrap_redir");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step("wrap");

    // Reset in the middle of a bubble, then the boot bubble again.
    drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0501);
    step("pre_rst_jump");
    async_reset("rst_bubble");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("reboot");
    step("reboot2");

    // Random control traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10, $urandom,
            $urandom_range(0, 99) < 12, $urandom);
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
